// File: rtl/doodle_pkg.sv
// doodle_pkg: shared constants and types for the Doodle Fall platform logic.
//   POS_W         : width of every horizontal/vertical position
//   VBP / VFP     : first / last visible line
//   HBP           : first visible pixel column
//   PLAT_WIDTH    : platform width in pixels (renderer/collision use)
//   ST_*          : platform_queue FSM encoding
//   queue_dbg_t   : FSM observation struct exported by platform_queue
//   popcount8     : number of set bits in an 8-bit vector
package doodle_pkg;

    localparam int POS_W      = 10;
    localparam int VBP        = 31;
    localparam int VFP        = 511;
    localparam int HBP        = 143;
    localparam int PLAT_WIDTH = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCROLL = 2'd1;
    localparam logic [1:0] ST_SPAWN  = 2'd2;

    typedef struct packed {
        logic [1:0]  state;
        logic [2:0]  idx;
        logic [10:0] gap_cnt;
    } queue_dbg_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/platform_slot.sv
// platform_slot: one platform's position/valid registers.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_scroll_en      : move this platform up one step this cycle (or retire it)
//   i_load_en        : spawn a new platform here at the bottom line
//   i_load_hpos      : horizontal position of the spawned platform
//   o_hpos, o_vpos   : current position
//   o_valid          : slot holds a live platform
//   o_valid_nxt      : value o_valid takes at the next edge (for the live count)
module platform_slot #(
    parameter int VBP  = doodle_pkg::VBP,
    parameter int VFP  = doodle_pkg::VFP,
    parameter int STEP = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_scroll_en,
    input  logic                         i_load_en,
    input  logic [doodle_pkg::POS_W-1:0] i_load_hpos,
    output logic [doodle_pkg::POS_W-1:0] o_hpos,
    output logic [doodle_pkg::POS_W-1:0] o_vpos,
    output logic                         o_valid,
    output logic                         o_valid_nxt
);
    import doodle_pkg::*;

    localparam logic [POS_W-1:0] RETIRE_BELOW = POS_W'(VBP + STEP);
    localparam logic [POS_W-1:0] STEP_V       = POS_W'(STEP);
    localparam logic [POS_W-1:0] SPAWN_LINE   = POS_W'(VFP);

    logic [POS_W-1:0] r_hpos;
    logic [POS_W-1:0] r_vpos;
    logic             r_valid;
    logic [POS_W-1:0] w_hpos_nxt;
    logic [POS_W-1:0] w_vpos_nxt;
    logic             w_valid_nxt;
    logic             w_retire;

    always_comb begin
        w_hpos_nxt  = r_hpos;
        w_vpos_nxt  = r_vpos;
        w_valid_nxt = r_valid;
        // Compare before subtracting so vpos never wraps below zero.
        w_retire    = r_valid && (r_vpos < RETIRE_BELOW);
        if (i_load_en) begin
            w_hpos_nxt  = i_load_hpos;
            w_vpos_nxt  = SPAWN_LINE;
            w_valid_nxt = 1'b1;
        end else if (i_scroll_en && r_valid) begin
            if (w_retire) begin
                w_valid_nxt = 1'b0;    // vpos is held for the retired slot
            end else begin
                w_vpos_nxt = r_vpos - STEP_V;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hpos  <= '0;
            r_vpos  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_hpos  <= w_hpos_nxt;
            r_vpos  <= w_vpos_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign o_hpos      = r_hpos;
    assign o_vpos      = r_vpos;
    assign o_valid     = r_valid;
    assign o_valid_nxt = w_valid_nxt;

endmodule

// File: rtl/platform_queue.sv
// platform_queue: fixed pool of platform slots, scrolled up once per frame,
// retired at the top edge and refilled at the bottom edge.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_frame_tick     : one-cycle pulse per video frame
//   i_pause          : high = ignore i_frame_tick
//   i_rand_hpos      : horizontal position for a spawn, sampled in SPAWN
//   o_plat_hpos/vpos : slot i at bits [10i+9:10i]
//   o_plat_valid     : slot live flags
//   o_active_cnt     : number of live slots (registered)
//   o_busy           : a frame update is in progress
//   o_spawn_pulse    : one cycle per successful spawn, with the new slot visible
//   o_overflow       : sticky, a spawn was dropped with every slot live
//   o_dbg            : FSM state, slot index and spawn gap accumulator
//
// Frame handshake: i_frame_tick is a fire-and-forget pulse with no ready.
// It is accepted only in the cycle the FSM is idle and i_pause is low; o_busy
// high means a tick in that cycle is dropped, never queued. An accepted tick
// in cycle t gives SCROLL in t+1..t+NUM_PLAT and SPAWN in t+NUM_PLAT+1.
module platform_queue #(
    parameter int NUM_PLAT    = 4,
    parameter int VBP         = doodle_pkg::VBP,
    parameter int VFP         = doodle_pkg::VFP,
    parameter int SCROLL_STEP = 2,
    parameter int SPAWN_GAP   = 120
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_frame_tick,
    input  logic                     i_pause,
    input  logic [9:0]               i_rand_hpos,
    output logic [10*NUM_PLAT-1:0]   o_plat_hpos,
    output logic [10*NUM_PLAT-1:0]   o_plat_vpos,
    output logic [NUM_PLAT-1:0]      o_plat_valid,
    output logic [3:0]               o_active_cnt,
    output logic                     o_busy,
    output logic                     o_spawn_pulse,
    output logic                     o_overflow,
    output doodle_pkg::queue_dbg_t   o_dbg
);
    import doodle_pkg::*;

    localparam logic [10:0] GAP_RST  = 11'(SPAWN_GAP - SCROLL_STEP);
    localparam logic [10:0] GAP_LIM  = 11'(SPAWN_GAP);
    localparam logic [10:0] GAP_STEP = 11'(SCROLL_STEP);
    localparam logic [2:0]  LAST_IDX = 3'(NUM_PLAT - 1);

    logic [1:0]          r_state;
    logic [2:0]          r_idx;
    logic [10:0]         r_gap_cnt;
    logic                r_spawn_pulse;
    logic                r_overflow;
    logic [3:0]          r_active_cnt;

    logic [NUM_PLAT-1:0] w_scroll_en;
    logic [NUM_PLAT-1:0] w_load_en;
    logic [NUM_PLAT-1:0] w_valid_nxt;
    logic [7:0]          w_valid_nxt_ext;
    logic [10:0]         w_gap_next;
    logic                w_spawn_due;
    logic                w_free_found;
    logic [2:0]          w_free_idx;

    // Lowest-index free slot; scrolling has finished by SPAWN, so a slot
    // retired this frame is already visible as free here.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = 3'd0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (!o_plat_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        w_gap_next  = r_gap_cnt + GAP_STEP;
        w_spawn_due = (r_state == ST_SPAWN) && (w_gap_next >= GAP_LIM);
        for (int i = 0; i < NUM_PLAT; i++) begin
            w_scroll_en[i] = (r_state == ST_SCROLL) && (r_idx == 3'(i));
            w_load_en[i]   = w_spawn_due && w_free_found && (w_free_idx == 3'(i));
        end
    end

    always_comb begin
        w_valid_nxt_ext                 = 8'd0;
        w_valid_nxt_ext[NUM_PLAT-1:0]   = w_valid_nxt;
    end

    for (genvar g = 0; g < NUM_PLAT; g++) begin : g_slot
        platform_slot #(
            .VBP  (VBP),
            .VFP  (VFP),
            .STEP (SCROLL_STEP)
        ) u_slot (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_scroll_en (w_scroll_en[g]),
            .i_load_en   (w_load_en[g]),
            .i_load_hpos (i_rand_hpos),
            .o_hpos      (o_plat_hpos[10*g +: 10]),
            .o_vpos      (o_plat_vpos[10*g +: 10]),
            .o_valid     (o_plat_valid[g]),
            .o_valid_nxt (w_valid_nxt[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_gap_cnt     <= GAP_RST;
            r_spawn_pulse <= 1'b0;
            r_overflow    <= 1'b0;
            r_active_cnt  <= 4'd0;
        end else begin
            r_spawn_pulse <= 1'b0;
            // Counts the slot values that land at this same edge.
            r_active_cnt  <= popcount8(w_valid_nxt_ext);
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_tick && !i_pause) begin
                        r_state <= ST_SCROLL;
                        r_idx   <= 3'd0;
                    end
                end
                ST_SCROLL: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_SPAWN;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ST_SPAWN: begin
                    r_state <= ST_IDLE;
                    r_idx   <= 3'd0;
                    if (w_gap_next >= GAP_LIM) begin
                        r_gap_cnt <= w_gap_next - GAP_LIM;
                        if (w_free_found) begin
                            r_spawn_pulse <= 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= w_gap_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

    assign o_active_cnt  = r_active_cnt;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_spawn_pulse = r_spawn_pulse;
    assign o_overflow    = r_overflow;
    assign o_dbg         = '{state: r_state, idx: r_idx, gap_cnt: r_gap_cnt};

endmodule

// File: tb/tb_platform_queue.sv
// Bench for platform_queue: two instances driven by the same stimulus, one
// with default parameters and one whose spawn line is 509 so a slot retires
// in the very frame a spawn is due.
module tb_platform_queue;

    localparam int NP    = 4;
    localparam int VBPL  = 31;
    localparam int STEP  = 2;
    localparam int GAP   = 120;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 frame_tick = 1'b0;
    logic                 pause = 1'b0;
    logic [9:0]           rand_hpos = 10'd0;

    logic [10*NP-1:0]     o_hpos   [2];
    logic [10*NP-1:0]     o_vpos   [2];
    logic [NP-1:0]        o_valid  [2];
    logic [3:0]           o_active [2];
    logic                 o_busy   [2];
    logic                 o_spawn  [2];
    logic                 o_ovf    [2];
    doodle_pkg::queue_dbg_t o_dbg  [2];

    always #5 clk = ~clk;

    platform_queue u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_tick  (frame_tick),
        .i_pause       (pause),
        .i_rand_hpos   (rand_hpos),
        .o_plat_hpos   (o_hpos[0]),
        .o_plat_vpos   (o_vpos[0]),
        .o_plat_valid  (o_valid[0]),
        .o_active_cnt  (o_active[0]),
        .o_busy        (o_busy[0]),
        .o_spawn_pulse (o_spawn[0]),
        .o_overflow    (o_ovf[0]),
        .o_dbg         (o_dbg[0])
    );

    platform_queue #(.VFP(509)) u_dut2 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_tick  (frame_tick),
        .i_pause       (pause),
        .i_rand_hpos   (rand_hpos),
        .o_plat_hpos   (o_hpos[1]),
        .o_plat_vpos   (o_vpos[1]),
        .o_plat_valid  (o_valid[1]),
        .o_active_cnt  (o_active[1]),
        .o_busy        (o_busy[1]),
        .o_spawn_pulse (o_spawn[1]),
        .o_overflow    (o_ovf[1]),
        .o_dbg         (o_dbg[1])
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is a list of platforms with a live flag; a frame moves
    // every live platform up, drops the ones that would leave the screen,
    // then adds to the scroll distance and spawns once it reaches the gap.
    int m_hpos  [2][NP];
    int m_vpos  [2][NP];
    bit m_valid [2][NP];
    int m_gap   [2];
    bit m_ovf   [2];
    int m_vfp   [2] = '{511, 509};
    bit last_spawn [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < NP; s++) begin
                m_hpos[d][s]  = 0;
                m_vpos[d][s]  = 0;
                m_valid[d][s] = 0;
            end
            m_gap[d] = GAP - STEP;
            m_ovf[d] = 0;
        end
    endtask

    task automatic model_frame(input int d, input int hpos, output bit spawned);
        int free_slot;
        spawned = 0;
        for (int s = 0; s < NP; s++) begin
            if (m_valid[d][s]) begin
                if (m_vpos[d][s] - STEP < VBPL) m_valid[d][s] = 0;
                else m_vpos[d][s] = m_vpos[d][s] - STEP;
            end
        end
        m_gap[d] = m_gap[d] + STEP;
        if (m_gap[d] >= GAP) begin
            m_gap[d] = m_gap[d] - GAP;
            free_slot = -1;
            for (int s = 0; s < NP; s++) begin
                if (!m_valid[d][s] && free_slot < 0) free_slot = s;
            end
            if (free_slot >= 0) begin
                m_hpos[d][free_slot]  = hpos;
                m_vpos[d][free_slot]  = m_vfp[d];
                m_valid[d][free_slot] = 1;
                spawned = 1;
            end else begin
                m_ovf[d] = 1;
            end
        end
    endtask

    task automatic check_state(input int d, input bit exp_spawn);
        logic [10*NP-1:0] eh;
        logic [10*NP-1:0] ev;
        logic [NP-1:0]    evd;
        int               cnt;
        cnt = 0;
        for (int s = 0; s < NP; s++) begin
            eh[10*s +: 10] = 10'(m_hpos[d][s]);
            ev[10*s +: 10] = 10'(m_vpos[d][s]);
            evd[s]         = m_valid[d][s];
            cnt            = cnt + int'(m_valid[d][s]);
        end
        chk($sformatf("d%0d_spawn_pulse", d), 64'(o_spawn[d]), 64'(exp_spawn));
        chk($sformatf("d%0d_valid", d), 64'(o_valid[d]), 64'(evd));
        chk($sformatf("d%0d_hpos", d), 64'(o_hpos[d]), 64'(eh));
        chk($sformatf("d%0d_vpos", d), 64'(o_vpos[d]), 64'(ev));
        chk($sformatf("d%0d_active_cnt", d), 64'(o_active[d]), 64'(cnt));
        chk($sformatf("d%0d_overflow", d), 64'(o_ovf[d]), 64'(m_ovf[d]));
        chk($sformatf("d%0d_gap_cnt", d), 64'(o_dbg[d].gap_cnt), 64'(m_gap[d]));
        chk($sformatf("d%0d_state_idle", d), 64'(o_dbg[d].state), 64'(doodle_pkg::ST_IDLE));
    endtask

    task automatic check_reset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_valid", d), 64'(o_valid[d]), 64'd0);
            chk($sformatf("d%0d_rst_hpos", d), 64'(o_hpos[d]), 64'd0);
            chk($sformatf("d%0d_rst_vpos", d), 64'(o_vpos[d]), 64'd0);
            chk($sformatf("d%0d_rst_active", d), 64'(o_active[d]), 64'd0);
            chk($sformatf("d%0d_rst_busy", d), 64'(o_busy[d]), 64'd0);
            chk($sformatf("d%0d_rst_spawn", d), 64'(o_spawn[d]), 64'd0);
            chk($sformatf("d%0d_rst_ovf", d), 64'(o_ovf[d]), 64'd0);
            chk($sformatf("d%0d_rst_state", d), 64'(o_dbg[d].state), 64'd0);
            chk($sformatf("d%0d_rst_idx", d), 64'(o_dbg[d].idx), 64'd0);
            chk($sformatf("d%0d_rst_gap", d), 64'(o_dbg[d].gap_cnt), 64'(GAP - STEP));
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge. extra_k in 1..NP+1 pulses frame_tick
    // again in busy cycle t+extra_k; pause_mid raises pause from t+2.
    task automatic do_frame(input logic [9:0] hpos, input bit p, input int extra_k, input bit pause_mid);
        bit sp0;
        bit sp1;
        frame_tick = 1'b1;
        pause      = p;
        rand_hpos  = hpos;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        if (p) begin
            pause = 1'b0;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_paused_busy", d), 64'(o_busy[d]), 64'd0);
                last_spawn[d] = o_spawn[d];
            end
            @(posedge clk); #1;
            check_state(0, 1'b0);
            check_state(1, 1'b0);
            return;
        end
        for (int k = 1; k <= NP + 1; k++) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_busy_k%0d", d, k), 64'(o_busy[d]), 64'd1);
            end
            frame_tick = (k == extra_k);
            if (pause_mid && k == 2) pause = 1'b1;
            @(posedge clk); #1;
        end
        frame_tick = 1'b0;
        pause      = 1'b0;
        model_frame(0, int'(hpos), sp0);
        model_frame(1, int'(hpos), sp1);
        last_spawn[0] = o_spawn[0];
        last_spawn[1] = o_spawn[1];
        check_state(0, sp0);
        check_state(1, sp1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_busy_done", d), 64'(o_busy[d]), 64'd0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_spawn_one_cycle", d), 64'(o_spawn[d]), 64'd0);
        end
    endtask

    // ---------------- directed vectors (instance 0) ----------------
    typedef struct {
        bit         pause;
        int         extra_k;
        logic [9:0] hpos;
        bit         exp_spawn;
        logic [3:0] exp_valid;
        logic [3:0] exp_active;
        logic [10:0] exp_gap;
        logic [9:0] exp_v0;
    } frame_vec_t;

    frame_vec_t tbl [5];

    initial begin
        int         fr;
        logic [9:0] cur;

        tbl[0] = '{pause: 1'b0, extra_k: 0, hpos: 10'd400, exp_spawn: 1'b1, exp_valid: 4'b0001, exp_active: 4'd1, exp_gap: 11'd0, exp_v0: 10'd511};
        tbl[1] = '{pause: 1'b0, extra_k: 2, hpos: 10'd350, exp_spawn: 1'b0, exp_valid: 4'b0001, exp_active: 4'd1, exp_gap: 11'd2, exp_v0: 10'd509};
        tbl[2] = '{pause: 1'b1, extra_k: 0, hpos: 10'd350, exp_spawn: 1'b0, exp_valid: 4'b0001, exp_active: 4'd1, exp_gap: 11'd2, exp_v0: 10'd509};
        tbl[3] = '{pause: 1'b0, extra_k: 4, hpos: 10'd350, exp_spawn: 1'b0, exp_valid: 4'b0001, exp_active: 4'd1, exp_gap: 11'd4, exp_v0: 10'd507};
        tbl[4] = '{pause: 1'b0, extra_k: 0, hpos: 10'd350, exp_spawn: 1'b0, exp_valid: 4'b0001, exp_active: 4'd1, exp_gap: 11'd6, exp_v0: 10'd505};

        // ---- reset ----
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- table frames ----
        fr = 0;
        for (int i = 0; i < 5; i++) begin
            do_frame(tbl[i].hpos, tbl[i].pause, tbl[i].extra_k, 1'b0);
            if (!tbl[i].pause) fr++;
            chk($sformatf("tbl%0d_spawn", i), 64'(last_spawn[0]), 64'(tbl[i].exp_spawn));
            chk($sformatf("tbl%0d_valid", i), 64'(o_valid[0]), 64'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_active", i), 64'(o_active[0]), 64'(tbl[i].exp_active));
            chk($sformatf("tbl%0d_gap", i), 64'(o_dbg[0].gap_cnt), 64'(tbl[i].exp_gap));
            chk($sformatf("tbl%0d_v0", i), 64'(o_vpos[0][9:0]), 64'(tbl[i].exp_v0));
            chk($sformatf("tbl%0d_h0", i), 64'(o_hpos[0][9:0]), 64'd400);
        end

        // ---- long run to the full pool and same-frame reuse ----
        while (fr < 301) begin
            cur = (fr + 1 <= 61) ? 10'd350 : 10'($urandom_range(0, 1023));
            do_frame(cur, 1'b0, 0, 1'b0);
            fr++;
            if (fr == 61) begin
                chk("f61_spawn", 64'(last_spawn[0]), 64'd1);
                chk("f61_v0", 64'(o_vpos[0][9:0]), 64'd391);
                chk("f61_h1", 64'(o_hpos[0][19:10]), 64'd350);
                chk("f61_v1", 64'(o_vpos[0][19:10]), 64'd511);
                chk("f61_valid", 64'(o_valid[0]), 64'b0011);
            end
            if (fr == 241) begin
                chk("f241_v0", 64'(o_vpos[0][9:0]), 64'd31);
                chk("f241_valid", 64'(o_valid[0]), 64'b1111);
                chk("f241_ovf", 64'(o_ovf[0]), 64'd1);
                chk("f241_spawn", 64'(last_spawn[0]), 64'd0);
                chk("f241_d2_spawn", 64'(last_spawn[1]), 64'd1);
                chk("f241_d2_h0", 64'(o_hpos[1][9:0]), 64'(cur));
                chk("f241_d2_v0", 64'(o_vpos[1][9:0]), 64'd509);
                chk("f241_d2_ovf", 64'(o_ovf[1]), 64'd0);
            end
            if (fr == 242) begin
                chk("f242_valid", 64'(o_valid[0]), 64'b1110);
                chk("f242_active", 64'(o_active[0]), 64'd3);
            end
            if (fr == 301) begin
                chk("f301_d2_spawn", 64'(last_spawn[1]), 64'd1);
                chk("f301_d2_h1", 64'(o_hpos[1][19:10]), 64'(cur));
                chk("f301_d2_v1", 64'(o_vpos[1][19:10]), 64'd509);
                chk("f301_d2_valid", 64'(o_valid[1]), 64'b1111);
                chk("f301_d2_ovf", 64'(o_ovf[1]), 64'd0);
            end
        end

        // ---- randomized frames against the model ----
        for (int i = 0; i < 120; i++) begin
            do_frame(10'($urandom_range(0, 1023)), ($urandom_range(0, 5) == 0),
                     int'($urandom_range(0, NP + 1)), 1'($urandom_range(0, 1)));
        end

        // ---- reset in the middle of SCROLL ----
        frame_tick = 1'b1;
        @(posedge clk); #1;      // t+1
        frame_tick = 1'b0;
        @(posedge clk); #1;      // t+2
        @(posedge clk); #1;      // t+3
        rst = 1'b1;
        @(posedge clk); #1;      // t+4
        check_reset();
        rst = 1'b0;
        model_reset();
        do_frame(10'd777, 1'b0, 0, 1'b0);
        chk("post_rst_spawn", 64'(last_spawn[0]), 64'd1);
        chk("post_rst_h0", 64'(o_hpos[0][9:0]), 64'd777);
        chk("post_rst_valid", 64'(o_valid[0]), 64'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
